// File: rtl/decode_writeback.sv
// rtl/decode_writeback.sv - SEQ Y86-64 decode/write-back stage; optional cmov gating via DECODE_CMOV_EN
module decode_writeback #(
   parameter logic [63:0] RSP_INIT = 64'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        hlt,
   input  logic        invalid_instruction,
   input  logic        invalid_instruction_address,
   input  logic        cnd,
   input  logic [63:0] valE,
   input  logic [63:0] valM,
   input  logic        dmem_error,
   input  logic        wr_en,
   output logic [3:0]  srcA,
   output logic [3:0]  srcB,
   output logic [3:0]  dstE,
   output logic [3:0]  dstM,
   output logic [63:0] valA,
   output logic [63:0] valB,
   output logic [2:0]  stat,
   output logic        halted,
   input  logic [3:0]  dbg_sel,
   output logic [63:0] dbg_val
);

   localparam logic [3:0] RNONE = 4'hF;
   localparam logic [3:0] RSP   = 4'h4;

   typedef enum logic [2:0] {
      ST_AOK = 3'd1,
      ST_HLT = 3'd2,
      ST_ADR = 3'd3,
      ST_INS = 3'd4
   } stat_e;

   stat_e       stat_q, stat_d;
   logic [63:0] rf_q [0:14];
   logic        commit;
   logic        fault;
   logic        we_e;
   logic        we_m;

   // The condition code itself is evaluated in execute; ifun is not needed here.
   logic unused_ifun;
   assign unused_ifun = &{1'b0, ifun};

   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      case (icode)
         4'h2: begin
            srcA = rA;
`ifdef DECODE_CMOV_EN
            dstE = cnd ? rB : RNONE;
`else
            dstE = rB;
`endif
         end
         4'h3: dstE = rB;
         4'h4: begin
            srcA = rA;
            srcB = rB;
         end
         4'h5: begin
            srcB = rB;
            dstM = rA;
         end
         4'h6: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         4'h8: begin
            srcB = RSP;
            dstE = RSP;
         end
         4'h9: begin
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
         end
         4'hA: begin
            srcA = rA;
            srcB = RSP;
            dstE = RSP;
         end
         4'hB: begin
            srcA = RSP;
            srcB = RSP;
            dstE = RSP;
            dstM = rA;
         end
         default: ;
      endcase
   end

`ifndef DECODE_CMOV_EN
   logic unused_cnd;
   assign unused_cnd = &{1'b0, cnd};
`endif

   assign valA    = (srcA == RNONE) ? 64'd0 : rf_q[srcA];
   assign valB    = (srcB == RNONE) ? 64'd0 : rf_q[srcB];
   assign dbg_val = (dbg_sel == RNONE) ? 64'd0 : rf_q[dbg_sel];

   assign commit = wr_en && (stat_q == ST_AOK);
   assign fault  = invalid_instruction_address || dmem_error || invalid_instruction;
   assign we_e   = commit && !fault && (dstE != RNONE);
   assign we_m   = commit && !fault && (dstM != RNONE);

   always_comb begin
      stat_d = stat_q;
      if (commit) begin
         if (invalid_instruction_address || dmem_error) stat_d = ST_ADR;
         else if (invalid_instruction)                  stat_d = ST_INS;
         else if (hlt || icode == 4'h0)                 stat_d = ST_HLT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stat_q <= ST_AOK;
      else        stat_q <= stat_d;
   end

   // valM is written second so it wins when dstE == dstM (popq %rsp).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) rf_q[i] <= (i == 4) ? RSP_INIT : 64'd0;
      end else begin
         if (we_e) rf_q[dstE] <= valE;
         if (we_m) rf_q[dstM] <= valM;
      end
   end

   assign stat   = stat_q;
   assign halted = (stat_q != ST_AOK);

endmodule

// File: doc/decode_writeback.md
# decode_writeback

Decode and write-back stage of the SEQ Y86-64 processor. It sits directly downstream of fetch and consumes `icode`, `ifun`, `rA`, `rB` and the fetch status flags. It owns the 15-entry 64-bit program register file. It derives `srcA`/`srcB`/`dstE`/`dstM`, supplies `valA`/`valB` combinationally to execute, and commits `valE`/`valM` on the clock edge that ends each instruction. It also maintains the sticky processor status.

## Interface
- `RSP_INIT`, default 64'd0: reset value of register 4 (`%rsp`).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `icode`  in  4  instruction code from fetch.
- `ifun`  in  4  function code from fetch.
- `rA`  in  4  register specifier A from fetch.
- `rB`  in  4  register specifier B from fetch.
- `hlt`  in  1  fetch saw halt.
- `invalid_instruction`  in  1  fetch saw an illegal icode/ifun.
- `invalid_instruction_address`  in  1  fetch saw a bad PC.
- `cnd`  in  1  condition result from execute (cmov).
- `valE`  in  64  ALU result.
- `valM`  in  64  memory read data.
- `dmem_error`  in  1  data-memory address error this instruction.
- `wr_en`  in  1  instruction completes this cycle; commit write-back.
- `srcA`, `srcB`, `dstE`, `dstM`  out  4 each  decoded register IDs; 4'hF = none.
- `valA`, `valB`  out  64 each  register read data.
- `stat`  out  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- `halted`  out  1  high when `stat` != AOK.
- `dbg_sel`  in  4  debug read select.
- `dbg_val`  out  64  debug read data.

## Operation
- `srcA`:
  - `rA` for icode 2, 4, 6, A.
  - 4 for icode 9, B.
  - F otherwise.
- `srcB`:
  - `rB` for icode 4, 5, 6.
  - 4 for icode 8, 9, A, B.
  - F otherwise.
- `dstE`:
  - `rB` for icode 3, 6.
  - `rB` for icode 2 subject to the Configuration rule.
  - 4 for icode 8, 9, A, B.
  - F otherwise.
- `dstM`: `rA` for icode 5, B; F otherwise.
- Reads of ID F return 64'd0. `dbg_val` follows the same rule.
- Reads are read-before-write. `valA`/`valB` in a commit cycle show pre-commit contents.
- Commit happens on a rising edge with `wr_en`=1 and `halted`=0:
  - `reg[dstE]` <= `valE` if `dstE`!=F.
  - `reg[dstM]` <= `valM` if `dstM`!=F.
  - If `dstE`==`dstM`, `valM` wins (popq %rsp).
- Status update, on the same edge, first match wins:
  - `invalid_instruction_address` or `dmem_error` -> ADR.
  - `invalid_instruction` -> INS.
  - `hlt` or icode 0 -> HLT.
  - Otherwise unchanged.
- Status is sticky. Once `stat` != AOK, all further writes and status changes are blocked until reset.
- The faulting instruction's own register writes are suppressed when it sets ADR or INS. A halt instruction writes nothing anyway.
- No other state machine: two states, RUN (AOK) and STOP (HLT/ADR/INS). RUN->STOP on a qualifying commit edge; STOP->RUN only via `rst_n`.

## Timing
- Decode IDs, `valA`, `valB`, `dbg_val`: combinational, zero latency.
- Register writes are visible on reads one cycle after the commit edge.
- `stat`/`halted` are registered and update on the commit edge.
- Reset, asynchronous assert, independent of `clk`:
  - All registers 0, except reg 4 = `RSP_INIT`.
  - `stat`=1, `halted`=0.
- Reset asserted coincident with a commit edge: reset wins, nothing is written.
- `wr_en`=0: no state changes regardless of other inputs.

## Configuration
- `DECODE_CMOV_EN`:
  - Defined: icode 2 writes `rB` only when `cnd`=1. With `cnd`=0, `dstE`=F.
  - Undefined: icode 2 always writes `rB` (rrmovq only), and `ifun`/`cnd` are ignored.

## Test plan
- Reset with `RSP_INIT`=64'h200:
  - `dbg_sel`=4 -> 64'h200.
  - `dbg_sel`=0..3, 5..E -> 0; `stat`=1.
- irmovq (icode 3, `rB`=2, `valE`=64'h1234, `wr_en`=1) -> `dstE`=2, `dstM`=F; next cycle `dbg_val`[2]=64'h1234.
- popq %rsp (icode B, `rA`=4, `valE`=64'h208, `valM`=64'hABCD) -> reg 4 = 64'hABCD, not 64'h208.
- cmov with `DECODE_CMOV_EN`, icode 2, `rA`=1, `rB`=3, `cnd`=0 -> `dstE`=F, reg 3 unchanged. Repeat with `cnd`=1 -> reg 3 = `valE`.
- Halt, then OPq with `dstE`=5, `valE`=7 -> `stat`=2, `halted`=1, reg 5 stays 0. Assert `rst_n`=0 mid-cycle -> `stat`=1 immediately.
- `invalid_instruction_address`=1 with `dmem_error`=0 and `invalid_instruction`=1 in the same commit -> `stat`=3 (ADR priority); no register written.
